// File: rtl/ysyx_23060171_trap_ctrl.sv
// Trap/return controller: takes trap-entry and mret decisions from the IDU,
// pulses the CSR file on trap entry and redirects the IFU to mtvec or mepc.
module ysyx_23060171_trap_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic                  in_ecall,
    input  logic                  in_ebreak,
    input  logic                  in_illegal,
    input  logic                  in_mret,
    input  logic                  in_csr_wen,
    input  logic [ADDR_WIDTH-1:0] in_csr_waddr,
    input  logic [DATA_WIDTH-1:0] in_csr_wdata,
    input  logic [DATA_WIDTH-1:0] csr_mtvec,
    input  logic [DATA_WIDTH-1:0] csr_mepc,
    output logic                  csr_irq,
    output logic [7:0]            csr_irq_no,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    output logic [ADDR_WIDTH-1:0] csr_waddr,
    output logic                  csr_wen,
    output logic                  redirect_valid,
    input  logic                  redirect_ready,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  busy,
    output logic [31:0]           trap_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRAP  = 2'd1,
        REDIR = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [7:0]            cause_q;
    logic                  is_mret_q;
    logic [31:0]           trap_cnt_q;
    logic                  accept;
    logic                  any_trap;
    logic [7:0]            cause_d;

    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    // mret combined with any trap flag is a malformed instruction, so it enters as illegal.
    assign any_trap = in_ecall || in_ebreak || in_illegal;
    assign cause_d  = (in_illegal || in_mret) ? 8'd2 :
                      in_ebreak               ? 8'd3 : 8'd11;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            trap_cnt_q <= 32'd0;
        end else begin
            state <= state_next;
            if (state == TRAP)
                trap_cnt_q <= trap_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pc_q      <= in_pc;
            cause_q   <= cause_d;
            is_mret_q <= in_mret && !any_trap;
        end
    end

    always_comb begin
        state_next     = state;
        csr_irq        = 1'b0;
        csr_irq_no     = cause_q;
        csr_wdata      = in_csr_wdata;
        csr_waddr      = in_csr_waddr;
        csr_wen        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = is_mret_q ? csr_mepc : {csr_mtvec[DATA_WIDTH-1:2], 2'b00};
        case (state)
            IDLE: begin
                if (accept) begin
                    if (any_trap)
                        state_next = TRAP;
                    else if (in_mret)
                        state_next = REDIR;
                    else
                        csr_wen = in_csr_wen;
                end
            end
            TRAP: begin
                csr_irq    = !rst;
                csr_wdata  = pc_q;
                state_next = REDIR;
            end
            REDIR: begin
                redirect_valid = !rst;
                if (redirect_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign trap_cnt = trap_cnt_q;

endmodule

// File: tb/tb_ysyx_23060171_trap_ctrl.sv
// Randomized scoreboard bench for the trap controller: the driver pushes expected
// CSR writes, trap pulses and redirects; a monitor pops them as the DUT presents them.
module tb_ysyx_23060171_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic        in_ecall = 1'b0, in_ebreak = 1'b0, in_illegal = 1'b0, in_mret = 1'b0;
    logic        in_csr_wen = 1'b0;
    logic [11:0] in_csr_waddr = '0;
    logic [31:0] in_csr_wdata = '0;
    logic [31:0] csr_mtvec = '0, csr_mepc = '0;
    logic        csr_irq;
    logic [7:0]  csr_irq_no;
    logic [31:0] csr_wdata;
    logic [11:0] csr_waddr;
    logic        csr_wen;
    logic        redirect_valid;
    logic        redirect_ready = 1'b0;
    logic [31:0] redirect_pc;
    logic        busy;
    logic [31:0] trap_cnt;

    ysyx_23060171_trap_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_ecall(in_ecall), .in_ebreak(in_ebreak), .in_illegal(in_illegal), .in_mret(in_mret),
        .in_csr_wen(in_csr_wen), .in_csr_waddr(in_csr_waddr), .in_csr_wdata(in_csr_wdata),
        .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc), .csr_irq(csr_irq), .csr_irq_no(csr_irq_no),
        .csr_wdata(csr_wdata), .csr_waddr(csr_waddr), .csr_wen(csr_wen),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc), .busy(busy), .trap_cnt(trap_cnt)
    );

    always #5 clk = ~clk;

    localparam int EV_WR = 0, EV_IRQ = 1, EV_RED = 2;
    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } ev_t;

    ev_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_cnt = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c);
        ev_t e;
        e.kind = kind; e.a = a; e.b = b; e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic pop(input int kind, output ev_t e, output bit ok);
        ok = 1'b0;
        e.kind = -1; e.a = '0; e.b = '0; e.c = '0;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d expected none at %0t", kind, $time);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(e.kind), 32'(kind));
            ok = (e.kind == kind);
        end
    endtask

    // Monitor: samples one time unit before each rising edge.
    initial begin : monitor
        ev_t         e;
        bit          ok;
        bit          have_pc = 1'b0;
        logic [31:0] held_pc = '0;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                check("rst_irq", 32'(csr_irq), 32'd0);
                check("rst_wen", 32'(csr_wen), 32'd0);
                check("rst_redir", 32'(redirect_valid), 32'd0);
                check("rst_ready", 32'(in_ready), 32'd0);
                have_pc = 1'b0;
            end else begin
                check("irq_wen_excl", 32'(csr_irq & csr_wen), 32'd0);
                if (csr_wen) begin
                    pop(EV_WR, e, ok);
                    if (ok) begin
                        check("wr_addr", 32'(csr_waddr), e.a);
                        check("wr_data", csr_wdata, e.b);
                    end
                end
                if (csr_irq) begin
                    pop(EV_IRQ, e, ok);
                    if (ok) begin
                        check("irq_no", 32'(csr_irq_no), e.a);
                        check("irq_wdata", csr_wdata, e.b);
                        check("irq_cnt", trap_cnt, e.c);
                    end
                end
                if (redirect_valid) begin
                    if (have_pc) check("redir_stable", redirect_pc, held_pc);
                    held_pc = redirect_pc;
                    have_pc = 1'b1;
                    if (redirect_ready) begin
                        pop(EV_RED, e, ok);
                        if (ok) begin
                            check("redir_pc", redirect_pc, e.a);
                            check("redir_cnt", trap_cnt, e.c);
                        end
                        have_pc = 1'b0;
                    end
                end else begin
                    have_pc = 1'b0;
                end
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    // One instruction through the block; hold = cycles redirect_ready stays low.
    task automatic txn(input logic ec, input logic eb, input logic il, input logic mr,
                       input logic wen, input logic [11:0] waddr, input logic [31:0] wdata,
                       input logic [31:0] pc, input logic [31:0] mtvec,
                       input logic [31:0] mepc, input int hold);
        bit   trap;
        bit   ret;
        int   ncyc;
        logic [7:0] cause;
        wait_ready();
        trap = ec || eb || il;
        ret  = mr && !trap;
        if (il || (mr && trap)) cause = 8'd2;
        else if (eb)            cause = 8'd3;
        else                    cause = 8'd11;
        in_valid = 1'b1; in_pc = pc;
        in_ecall = ec; in_ebreak = eb; in_illegal = il; in_mret = mr;
        in_csr_wen = wen; in_csr_waddr = waddr; in_csr_wdata = wdata;
        csr_mtvec = mtvec; csr_mepc = mepc; redirect_ready = 1'b0;
        if (trap) begin
            push(EV_IRQ, 32'(cause), pc, model_cnt);
            model_cnt = model_cnt + 32'd1;
            push(EV_RED, mtvec & 32'hFFFF_FFFC, 32'd0, model_cnt);
        end else if (ret) begin
            push(EV_RED, mepc, 32'd0, model_cnt);
        end else if (wen) begin
            push(EV_WR, 32'(waddr), wdata, 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        {in_ecall, in_ebreak, in_illegal, in_mret, in_csr_wen} = 5'($urandom);
        in_pc = $urandom;
        if (trap) begin
            #4;
            check("irq_latency", 32'(csr_irq), 32'd1);
            check("trap_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        if (trap || ret) begin
            ncyc = 0;
            for (int k = 0; k < 60; k++) begin
                redirect_ready = (k >= hold);
                #4;
                if (!redirect_valid) begin
                    check("redir_valid", 32'(redirect_valid), 32'd1);
                    break;
                end
                ncyc++;
                check("redir_ready_low", 32'(in_ready), 32'd0);
                if (ret) check("mret_no_irq", 32'(csr_irq), 32'd0);
                @(posedge clk);
                if (redirect_ready) break;
                @(negedge clk);
            end
            check("redir_cycles", 32'(ncyc), 32'(hold + 1));
            @(negedge clk);
            redirect_ready = 1'b0;
        end
        #4;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ready", 32'(in_ready), 32'd1);
    endtask

    // Accept a trap or mret, then assert reset while the block is mid-operation.
    task automatic reset_mid(input bit in_redir);
        wait_ready();
        in_valid = 1'b1; in_pc = 32'h8000_0040;
        in_ecall = !in_redir; in_ebreak = 1'b0; in_illegal = 1'b0; in_mret = in_redir;
        in_csr_wen = 1'b0; csr_mtvec = 32'h8000_0100; csr_mepc = 32'h8000_0200;
        redirect_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #4;
        check("rst_cnt", trap_cnt, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_cnt = 32'd0;
        #4;
        check("post_rst_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #4;
            check("post_rst_irq", 32'(csr_irq), 32'd0);
            check("post_rst_redir", 32'(redirect_valid), 32'd0);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #4;
        check("reset_ready", 32'(in_ready), 32'd1);
        check("reset_cnt", trap_cnt, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        txn(1, 0, 0, 0, 0, 12'h0, 32'h0, 32'h8000_0010, 32'h8000_0103, 32'h0, 0);
        check("ecall_cnt", trap_cnt, 32'd1);
        txn(0, 0, 0, 1, 0, 12'h0, 32'h0, 32'h8000_0020, 32'h8000_0100, 32'h8000_0014, 3);
        txn(1, 1, 1, 0, 0, 12'h0, 32'h0, 32'h8000_0030, 32'h8000_0100, 32'h8000_0014, 1);
        txn(1, 0, 0, 1, 0, 12'h0, 32'h0, 32'h8000_0034, 32'h8000_0200, 32'h8000_0014, 0);
        txn(0, 1, 0, 0, 0, 12'h0, 32'h0, 32'h8000_0038, 32'h8000_0200, 32'h0, 0);
        txn(0, 0, 0, 0, 1, 12'h305, 32'h8000_0200, 32'h8000_0040, 32'h0, 32'h0, 0);
        txn(1, 0, 0, 0, 1, 12'h305, 32'h8000_0200, 32'h8000_0044, 32'h8000_0300, 32'h0, 0);
        txn(0, 0, 0, 1, 1, 12'h341, 32'h1234_5678, 32'h8000_0048, 32'h0, 32'h8000_0050, 2);

        reset_mid(1'b0);
        reset_mid(1'b1);

        // Counter wrap: deposit a value near the top, then two back-to-back ecalls.
        @(negedge clk);
        dut.trap_cnt_q = 32'hFFFF_FFFE;
        model_cnt = 32'hFFFF_FFFE;
        txn(1, 0, 0, 0, 0, 12'h0, 32'h0, 32'h8000_0060, 32'h8000_0100, 32'h0, 0);
        check("cnt_max", trap_cnt, 32'hFFFF_FFFF);
        txn(1, 0, 0, 0, 0, 12'h0, 32'h0, 32'h8000_0064, 32'h8000_0100, 32'h0, 0);
        check("cnt_wrap", trap_cnt, 32'd0);

        for (int n = 0; n < 200; n++) begin
            txn(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                1'($urandom), 12'($urandom), $urandom, $urandom, $urandom, $urandom,
                int'($urandom_range(0, 3)));
        end

        repeat (4) @(negedge clk);
        check("queue_drain", 32'(exp_q.size()), 32'd0);
        check("final_cnt", trap_cnt, model_cnt);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
